// File: rtl/rf_writeback_if.sv
// Register-file writeback port bundle: ALU and MD producer inputs, register-file
// write outputs and the pending-write scoreboard seen by decode.
interface rf_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NREG = 2 ** ADDR_W;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rw;
  logic [DATA_W-1:0] alu_rd;
  logic              alu_stall;

  logic              md_issue;
  logic [ADDR_W-1:0] md_issue_rw;
  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_rw;
  logic [DATA_W-1:0] md_rd;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_rw;
  logic [DATA_W-1:0] rf_rd;

  logic [NREG-1:0]   busy;
  logic              waw_err;

  modport master (
    output alu_valid, alu_rw, alu_rd,
    output md_issue, md_issue_rw, md_valid, md_rw, md_rd,
    input  alu_stall, md_ready,
    input  rf_we, rf_rw, rf_rd,
    input  busy, waw_err
  );

  modport slave (
    input  alu_valid, alu_rw, alu_rd,
    input  md_issue, md_issue_rw, md_valid, md_rw, md_rd,
    output alu_stall, md_ready,
    output rf_we, rf_rw, rf_rd,
    output busy, waw_err
  );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write port arbiter: ALU results win, MD results queue in a FIFO.
// Define RF_WB_STARVE_EN to force the MD head out after STARVE_LIMIT ALU-won cycles.
module rf_writeback #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic          clk,
  input logic          reset,
  rf_writeback_if.slave wb
);
  localparam int NREG  = 2 ** ADDR_W;
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("rf_writeback: FIFO_DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
  end

  logic [ADDR_W-1:0] fifo_rw [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_rd [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic              force_md;
  logic              sel_alu;
  logic              sel_md;
  logic [ADDR_W-1:0] sel_rw;
  logic [DATA_W-1:0] sel_rd;
  logic [ADDR_W-1:0] head_rw;
  logic [DATA_W-1:0] head_rd;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_rw_q;
  logic [DATA_W-1:0] rf_rd_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_nxt;
  logic              waw_q;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  assign head_rw = fifo_rw[rd_ptr[IDX_W-1:0]];
  assign head_rd = fifo_rd[rd_ptr[IDX_W-1:0]];

`ifdef RF_WB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Down-counts ALU-won cycles while MD waits; terminal count forces the MD head out.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= CNT_W'(STARVE_LIMIT);
    end else if (pop || empty) begin
      starve_cnt <= CNT_W'(STARVE_LIMIT);
    end else if (sel_alu) begin
      starve_cnt <= starve_cnt - 1'b1;
    end
  end

  assign force_md = (starve_cnt == '0) && !empty;
`else
  assign force_md = 1'b0;
`endif

  always_comb begin
    sel_alu = wb.alu_valid && !force_md;
    sel_md  = !sel_alu && !empty;
    pop     = sel_md;
    push    = wb.md_valid && !full;
    sel_rw  = sel_alu ? wb.alu_rw : head_rw;
    sel_rd  = sel_alu ? wb.alu_rd : head_rd;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[wr_ptr[IDX_W-1:0]] <= wb.md_rw;
      fifo_rd[wr_ptr[IDX_W-1:0]] <= wb.md_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Writes to register 0 are dropped at the enable; the FIFO entry still retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q <= 1'b0;
      rf_rw_q <= '0;
      rf_rd_q <= '0;
    end else if (sel_alu || sel_md) begin
      rf_we_q <= (sel_rw != '0);
      rf_rw_q <= sel_rw;
      rf_rd_q <= sel_rd;
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  // Issue is applied after the pop clear so a newer reservation survives.
  always_comb begin
    busy_nxt = busy_q;
    if (pop) busy_nxt[head_rw] = 1'b0;
    if (wb.md_issue && wb.md_issue_rw != '0) busy_nxt[wb.md_issue_rw] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (wb.alu_valid && wb.alu_rw != '0 && busy_q[wb.alu_rw]) waw_q <= 1'b1;
    end
  end

  assign wb.md_ready  = !full;
  assign wb.alu_stall = force_md;
  assign wb.rf_we     = rf_we_q;
  assign wb.rf_rw     = rf_rw_q;
  assign wb.rf_rd     = rf_rd_q;
  assign wb.busy      = busy_q;
  assign wb.waw_err   = waw_q;
endmodule
